// File: rtl/score_window_loader.sv
// score_window_loader: streams a song's note codes from a score ROM into a
// DEPTH-slot look-ahead window, advancing one note per beat.
//
// Ports
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   start_i         begin a song (accepted only in IDLE or DONE)
//   song_sel_i      song index, latched on an accepted start
//   tempo_period_i  clocks per beat, latched on an accepted start (min 2)
//   pause_i         freezes playback while high in PLAY/PAUSED
//   loop_en_i       restart the song at offset 0 when it ends
//   rom_addr_o      {latched song, note offset} to the score ROM
//   rom_data_i      ROM note, valid one clock after rom_addr_o changes
//   window_o        slot 0 (current note) in the low bits, newest slot on top
//   beat_o          one-clock pulse on every beat in PLAY/DRAIN
//   playing_o       high in PRIME, PLAY, PAUSED, DRAIN
//   done_o          high in DONE
//   note_index_o    current ROM note offset
module score_window_loader #(
    parameter int                NOTE_W   = 4,
    parameter int                DEPTH    = 16,
    parameter int                SONG_W   = 2,
    parameter int                OFF_W    = 7,
    parameter int                TEMPO_W  = 26,
    parameter logic [NOTE_W-1:0] END_CODE = '1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [SONG_W-1:0]         song_sel_i,
    input  logic [TEMPO_W-1:0]        tempo_period_i,
    input  logic                      pause_i,
    input  logic                      loop_en_i,
    output logic [SONG_W+OFF_W-1:0]   rom_addr_o,
    input  logic [NOTE_W-1:0]         rom_data_i,
    output logic [DEPTH*NOTE_W-1:0]   window_o,
    output logic                      beat_o,
    output logic                      playing_o,
    output logic                      done_o,
    output logic [OFF_W-1:0]          note_index_o
);
    localparam int DW = DEPTH * NOTE_W;
    localparam int PW = $clog2(2 * DEPTH);
    localparam logic [PW-1:0] PRIME_LAST = PW'(2 * DEPTH - 1);
    localparam logic [PW-1:0] DRAIN_LAST = PW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_PLAY,
        S_PAUSED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [TEMPO_W-1:0]  tempo_q, tempo_d;
    logic [TEMPO_W-1:0]  cnt_q, cnt_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic                ended_q, ended_d;
    logic [DW-1:0]       win_q, win_d;
    logic                beat_q, beat_d;

    logic                is_end_code;
    logic                song_end;
    logic [NOTE_W-1:0]   note_in;
    logic                beat_due;
    logic [TEMPO_W-1:0]  cnt_next;
    logic [DW-1:0]       win_note;
    logic [DW-1:0]       win_rest;

    // The last ROM offset counts as an end marker so the offset never wraps silently.
    assign is_end_code = rom_data_i == END_CODE;
    assign song_end    = is_end_code || (off_q == '1);
    assign note_in     = is_end_code ? '0 : rom_data_i;
    assign beat_due    = cnt_q == tempo_q - TEMPO_W'(1);
    assign cnt_next    = beat_due ? '0 : cnt_q + TEMPO_W'(1);
    assign win_note    = {note_in, win_q[DW-1:NOTE_W]};
    assign win_rest    = {{NOTE_W{1'b0}}, win_q[DW-1:NOTE_W]};

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        tempo_d = tempo_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        pcnt_d  = pcnt_q;
        ended_d = ended_q;
        win_d   = win_q;
        beat_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_PRIME;
                    song_d  = song_sel_i;
                    tempo_d = (tempo_period_i < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo_period_i;
                    cnt_d   = '0;
                    off_d   = '0;
                    pcnt_d  = '0;
                    ended_d = 1'b0;
                    win_d   = '0;
                end
            end
            S_PRIME: begin
                // Even pcnt values present the address, odd values capture the note.
                pcnt_d = pcnt_q + PW'(1);
                if (pcnt_q[0]) begin
                    win_d = ended_q ? win_rest : win_note;
                    if (!ended_q && song_end && !loop_en_i)
                        ended_d = 1'b1;
                    else if (!ended_q)
                        off_d = song_end ? '0 : off_q + OFF_W'(1);
                    if (pcnt_q == PRIME_LAST) begin
                        state_d = ended_d ? S_DRAIN : S_PLAY;
                        pcnt_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            S_PLAY: begin
                // A beat on the same clock as pause still completes.
                cnt_d = cnt_next;
                if (pause_i)
                    state_d = S_PAUSED;
                if (beat_due) begin
                    beat_d = 1'b1;
                    win_d  = win_note;
                    off_d  = song_end ? '0 : off_q + OFF_W'(1);
                    if (song_end && !loop_en_i) begin
                        off_d   = off_q;
                        pcnt_d  = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_PAUSED: begin
                if (!pause_i)
                    state_d = S_PLAY;
            end
            S_DRAIN: begin
                cnt_d = cnt_next;
                if (beat_due) begin
                    beat_d = 1'b1;
                    win_d  = win_rest;
                    pcnt_d = pcnt_q + PW'(1);
                    if (pcnt_q == DRAIN_LAST)
                        state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            song_q  <= '0;
            tempo_q <= '0;
            cnt_q   <= '0;
            off_q   <= '0;
            pcnt_q  <= '0;
            ended_q <= 1'b0;
            win_q   <= '0;
            beat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            tempo_q <= tempo_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            pcnt_q  <= pcnt_d;
            ended_q <= ended_d;
            win_q   <= win_d;
            beat_q  <= beat_d;
        end
    end

    assign rom_addr_o   = {song_q, off_q};
    assign window_o     = win_q;
    assign beat_o       = beat_q;
    assign playing_o    = (state_q == S_PRIME) || (state_q == S_PLAY) ||
                          (state_q == S_PAUSED) || (state_q == S_DRAIN);
    assign done_o       = state_q == S_DONE;
    assign note_index_o = off_q;

endmodule

// File: tb/tb_score_window_loader.sv
// tb_score_window_loader: randomized and directed checks of score_window_loader
// against a note-stream reference model kept in the bench.
module tb_score_window_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        loop_en = 1'b0;
    logic [1:0]  song_sel = '0;
    logic [25:0] tempo = '0;
    logic [3:0]  rom_data = '0;
    logic [8:0]  rom_addr;
    logic [63:0] window;
    logic        beat, playing, done;
    logic [6:0]  note_index;
    logic [3:0]  rom [0:511];
    logic [82:0] dut_vec;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    score_window_loader dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .song_sel_i(song_sel),
        .tempo_period_i(tempo), .pause_i(pause), .loop_en_i(loop_en),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data), .window_o(window),
        .beat_o(beat), .playing_o(playing), .done_o(done), .note_index_o(note_index)
    );

    assign dut_vec = {window, rom_addr, note_index, beat, playing, done};

    // Reference model: a note stream pulled from the ROM array, a countdown to
    // the next beat, and a window kept as a plain array of note values.
    localparam int M_IDLE = 0, M_PRIME = 1, M_PLAY = 2, M_PAUSED = 3, M_DRAIN = 4, M_DONE = 5;
    int m_mode, m_song, m_per, m_off, m_age, m_left, m_drained, m_next;
    bit m_stop, m_beat;
    int m_win [16];

    function automatic int fetch();
        int n;
        bit eos;
        if (m_stop) return 0;
        n = int'(rom[m_song * 128 + m_off]);
        eos = (n == 15) || (m_off == 127);
        if (eos) begin
            if (loop_en) m_off = 0;
            else m_stop = 1'b1;
        end else m_off++;
        return (n == 15) ? 0 : n;
    endfunction

    function automatic void push(input int n);
        for (int i = 0; i < 15; i++) m_win[i] = m_win[i+1];
        m_win[15] = n;
    endfunction

    function automatic logic [82:0] exp_vec();
        logic [63:0] w;
        for (int i = 0; i < 16; i++) w[i*4 +: 4] = 4'(m_win[i]);
        return {w, 2'(m_song), 7'(m_off), 7'(m_off), m_beat,
                (m_mode >= M_PRIME && m_mode <= M_DRAIN), (m_mode == M_DONE)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_song = 0; m_per = 0; m_off = 0; m_age = 0;
            m_left = 0; m_drained = 0; m_stop = 0; m_beat = 0;
            for (int i = 0; i < 16; i++) m_win[i] = 0;
        end else begin
            m_beat = 0;
            case (m_mode)
                M_IDLE, M_DONE: if (start) begin
                    m_song = int'(song_sel);
                    m_per = (tempo < 2) ? 2 : int'(tempo);
                    for (int i = 0; i < 16; i++) m_win[i] = 0;
                    m_off = 0; m_age = 0; m_stop = 0; m_mode = M_PRIME;
                end
                M_PRIME: begin
                    m_age++;
                    if (m_age % 2 == 0) begin
                        push(fetch());
                        if (m_age == 32) begin
                            m_mode = m_stop ? M_DRAIN : M_PLAY;
                            m_left = m_per;
                            m_drained = 0;
                        end
                    end
                end
                M_PLAY: begin
                    m_next = pause ? M_PAUSED : M_PLAY;
                    m_left--;
                    if (m_left == 0) begin
                        m_beat = 1; m_left = m_per;
                        push(fetch());
                        if (m_stop) begin m_next = M_DRAIN; m_drained = 0; end
                    end
                    m_mode = m_next;
                end
                M_PAUSED: if (!pause) m_mode = M_PLAY;
                M_DRAIN: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_beat = 1; m_left = m_per;
                        push(0);
                        m_drained++;
                        if (m_drained == 16) m_mode = M_DONE;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    function automatic logic [3:0] loop_seq(input int k);
        return ((k % 6) < 5) ? 4'((k % 6) + 1) : 4'd0;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; start = 1'b0; pause = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic start_song(input int s, input int tp, input bit lp);
        song_sel = 2'(s); tempo = 26'(tp); loop_en = lp; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #3;
        n_cmp++; if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", dut_vec); end
        repeat (2) @(negedge clk);
        n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_held: got %h expected %h", dut_vec, exp_vec()); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_idle: got %h expected 0", dut_vec); end
    endtask

    task automatic test_prime();
        int k, nb, cyc;
        start_song(0, 10, 0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL prime_model: got %h expected %h", dut_vec, exp_vec()); end
        end
        n_cmp++; if (window !== 64'h00ED_CBA9_8765_4321) begin n_fail++; $display("FAIL prime_window: got %h expected 00edcba987654321", window); end
        n_cmp++; if (playing !== 1'b1) begin n_fail++; $display("FAIL prime_playing: got %b expected 1", playing); end
        k = 0;
        do begin @(negedge clk); k++; end while (!beat && k < 100);
        n_cmp++; if (k !== 10) begin n_fail++; $display("FAIL first_beat_delay: got %0d expected 10", k); end
        nb = 1; cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (beat) nb++;
            n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL drain_model: got %h expected %h", dut_vec, exp_vec()); end
        end while (!done && cyc < 400);
        n_cmp++; if (nb !== 16) begin n_fail++; $display("FAIL drain_beats: got %0d expected 16", nb); end
        n_cmp++; if (window !== '0 || done !== 1'b1 || playing !== 1'b0) begin n_fail++; $display("FAIL done_state: got win %h done %b playing %b expected 0/1/0", window, done, playing); end
    endtask

    task automatic test_long_song();
        int nb, cyc;
        start_song(1, 2, 0);
        nb = 0; cyc = 0;
        do begin
            @(negedge clk); cyc++;
            n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL long_model: got %h expected %h", dut_vec, exp_vec()); end
            if (beat) begin
                nb++;
                if (nb == 112) begin
                    n_cmp++; if (window[63:60] !== 4'((127 % 14) + 1) || note_index !== 7'd127) begin n_fail++; $display("FAIL long_last_note: got note %h idx %0d expected %h idx 127", window[63:60], note_index, 4'((127 % 14) + 1)); end
                end
            end
        end while (!done && cyc < 2000);
        n_cmp++; if (nb !== 128) begin n_fail++; $display("FAIL long_beats: got %0d expected 128", nb); end
        n_cmp++; if (note_index !== 7'd127 || window !== '0) begin n_fail++; $display("FAIL long_end: got idx %0d win %h expected 127 / 0", note_index, window); end
    endtask

    task automatic test_loop();
        logic [63:0] w;
        int gap, b;
        bit saw_done;
        start_song(2, 4, 1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL loop_prime_model: got %h expected %h", dut_vec, exp_vec()); end
        end
        for (int i = 0; i < 16; i++) w[i*4 +: 4] = loop_seq(i);
        n_cmp++; if (window !== w) begin n_fail++; $display("FAIL loop_window: got %h expected %h", window, w); end
        gap = 0; b = 0; saw_done = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk); gap++;
            saw_done |= done;
            n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL loop_model: got %h expected %h", dut_vec, exp_vec()); end
            if (beat) begin
                n_cmp++; if (gap !== 4 || window[63:60] !== loop_seq(16 + b)) begin n_fail++; $display("FAIL loop_beat: got gap %0d note %h expected 4 / %h", gap, window[63:60], loop_seq(16 + b)); end
                b++; gap = 0;
            end
        end
        n_cmp++; if (saw_done !== 1'b0 || b !== 30) begin n_fail++; $display("FAIL loop_done: got done %b beats %0d expected 0 / 30", saw_done, b); end
    endtask

    task automatic test_pause();
        logic [63:0] saved;
        logic [6:0]  saved_idx;
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!beat && k < 20);
        n_cmp++; if (beat !== 1'b1) begin n_fail++; $display("FAIL pause_wait: got no beat expected beat within 20 clks"); end
        saved = window; saved_idx = note_index;
        pause = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_cmp++; if (beat !== 1'b0 || window !== saved || note_index !== saved_idx || playing !== 1'b1) begin n_fail++; $display("FAIL pause_hold: got beat %b win %h idx %0d expected 0 / %h / %0d", beat, window, note_index, saved, saved_idx); end
        end
        pause = 1'b0;
        @(negedge clk);
        k = 0;
        do begin @(negedge clk); k++; end while (!beat && k < 20);
        n_cmp++; if (k !== 3) begin n_fail++; $display("FAIL pause_resume: got %0d clks expected 3", k); end
        n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL pause_model: got %h expected %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_tempo_min();
        int gap;
        for (int tp = 0; tp < 2; tp++) begin
            do_reset();
            start_song(2, tp, 1);
            repeat (32) @(negedge clk);
            gap = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk); gap++;
                n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL tempo_model: got %h expected %h", dut_vec, exp_vec()); end
                if (beat) begin
                    n_cmp++; if (gap !== 2) begin n_fail++; $display("FAIL tempo_min_gap: got %0d expected 2 (period %0d)", gap, tp); end
                    gap = 0;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] saved;
        logic [8:0]  saved_addr;
        int k;
        do_reset();
        start_song(1, 5, 0);
        repeat (40) @(negedge clk);
        k = 0;
        do begin @(negedge clk); k++; end while (!beat && k < 20);
        saved = window; saved_addr = rom_addr;
        song_sel = 2'd3; tempo = 26'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_cmp++; if (window !== saved || rom_addr !== saved_addr || playing !== 1'b1) begin n_fail++; $display("FAIL start_ignored: got win %h addr %h expected %h / %h", window, rom_addr, saved, saved_addr); end
        n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL start_ignored_model: got %h expected %h", dut_vec, exp_vec()); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_mid_async: got %h expected 0", dut_vec); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if (beat !== 1'b0 || playing !== 1'b0 || dut_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_mid_idle: got %h expected %h", dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_random();
        for (int run = 0; run < 6; run++) begin
            do_reset();
            for (int i = 0; i < 128; i++) rom[384 + i] = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 2) != 0) rom[384 + $urandom_range(0, 40)] = 4'hF;
            start_song(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                n_cmp++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random_model run %0d cyc %0d: got %h expected %h", run, c, dut_vec, exp_vec()); end
                if ($urandom_range(0, 7) == 0) pause = ~pause;
                if ($urandom_range(0, 31) == 0) loop_en = ~loop_en;
                start = ($urandom_range(0, 19) == 0);
                song_sel = 2'($urandom_range(0, 3));
                tempo = 26'($urandom_range(0, 5));
            end
            start = 1'b0; pause = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            rom[i]       = (i < 14) ? 4'(i + 1) : ((i == 14) ? 4'hF : 4'h0);
            rom[128 + i] = 4'((i % 14) + 1);
            rom[256 + i] = (i < 5) ? 4'(i + 1) : ((i == 5) ? 4'hF : 4'h0);
            rom[384 + i] = 4'h0;
        end
        test_reset();
        test_prime();
        test_long_song();
        test_loop();
        test_pause();
        test_tempo_min();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
